// File: rtl/spike_count_decoder.sv
// Rate-coded readout: counts output-layer spikes over a window, then picks the busiest neuron.
// Latency: done follows window_len + NUM_OUTPUTS + 1 edges after start; no backpressure, abort cancels.
module spike_count_decoder #(
  parameter int NUM_OUTPUTS  = 4,
  parameter int COUNT_WIDTH  = 16,
  parameter int WINDOW_WIDTH = 16,
  localparam int CLASS_WIDTH = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_OUTPUTS-1:0]  spike_in,
  input  logic                    start,
  input  logic                    abort,
  input  logic [WINDOW_WIDTH-1:0] window_len,
  output logic                    net_clear,
  output logic                    busy,
  output logic                    done,
  output logic [CLASS_WIDTH-1:0]  class_out,
  output logic [COUNT_WIDTH-1:0]  max_count,
  output logic                    tie,
  output logic                    class_valid,
  input  logic [CLASS_WIDTH-1:0]  cnt_sel,
  output logic [COUNT_WIDTH-1:0]  cnt_dout
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    ARGMAX,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [COUNT_WIDTH-1:0]  cnt_q [NUM_OUTPUTS];
  logic [WINDOW_WIDTH-1:0] win_q;

  logic [CLASS_WIDTH-1:0]  scan_idx_q;
  logic [CLASS_WIDTH-1:0]  scan_best_q;
  logic [COUNT_WIDTH-1:0]  scan_max_q;
  logic                    scan_tie_q;

  logic [COUNT_WIDTH-1:0]  scan_cnt;
  logic [CLASS_WIDTH-1:0]  next_best;
  logic [COUNT_WIDTH-1:0]  next_max;
  logic                    next_tie;
  logic                    scan_last;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; abort outranks the normal RUN/ARGMAX exits
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        if (abort)                 state_d = IDLE;
        else if (window_len != '0) state_d = RUN;
        else                       state_d = ARGMAX;
      end
      RUN: begin
        if (abort)                                 state_d = IDLE;
        else if (win_q == WINDOW_WIDTH'(1))        state_d = ARGMAX;
      end
      ARGMAX: begin
        if (abort)          state_d = IDLE;
        else if (scan_last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign net_clear = (state_q == CLEAR);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  // Shared mux for the scan pointer and the readback port; unused codes read 0
  always_comb begin
    scan_cnt = '0;
    cnt_dout = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      if (scan_idx_q == CLASS_WIDTH'(i)) scan_cnt = cnt_q[i];
      if (cnt_sel == CLASS_WIDTH'(i))    cnt_dout = cnt_q[i];
    end
  end

  // One argmax step: strict greater-than keeps the lowest index on ties
  always_comb begin
    scan_last = (scan_idx_q == CLASS_WIDTH'(NUM_OUTPUTS - 1));
    if ((scan_idx_q == '0) || (scan_cnt > scan_max_q)) begin
      next_max  = scan_cnt;
      next_best = scan_idx_q;
      next_tie  = 1'b0;
    end else begin
      next_max  = scan_max_q;
      next_best = scan_best_q;
      next_tie  = scan_tie_q | (scan_cnt == scan_max_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) cnt_q[i] <= '0;
    end else if ((state_q == CLEAR) && !abort) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) cnt_q[i] <= '0;
    end else if (state_q == RUN) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        if (spike_in[i] && (cnt_q[i] != {COUNT_WIDTH{1'b1}})) begin
          cnt_q[i] <= cnt_q[i] + COUNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q <= '0;
    end else if ((state_q == CLEAR) && !abort) begin
      win_q <= window_len;
    end else if (state_q == RUN) begin
      win_q <= win_q - WINDOW_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_idx_q  <= '0;
      scan_best_q <= '0;
      scan_max_q  <= '0;
      scan_tie_q  <= 1'b0;
    end else if (state_q == CLEAR) begin
      scan_idx_q  <= '0;
    end else if (state_q == ARGMAX) begin
      scan_idx_q  <= scan_idx_q + CLASS_WIDTH'(1);
      scan_best_q <= next_best;
      scan_max_q  <= next_max;
      scan_tie_q  <= next_tie;
    end
  end

  // Results land on the edge into DONE so they are already valid while done is high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      class_out   <= '0;
      max_count   <= '0;
      tie         <= 1'b0;
      class_valid <= 1'b0;
    end else if ((state_q == CLEAR) && !abort) begin
      class_valid <= 1'b0;
    end else if ((state_q == ARGMAX) && scan_last && !abort) begin
      class_out   <= next_best;
      max_count   <= next_max;
      tie         <= next_tie;
      class_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spike_count_decoder.sv
// Bench for spike_count_decoder: per-scenario tasks against a counting/argmax reference model.
module tb_spike_count_decoder;
  localparam int N   = 4;
  localparam int CW  = 4;
  localparam int WW  = 16;
  localparam int CLW = 2;
  localparam int SAT = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           abort;
  logic [N-1:0]   spike_in;
  logic [WW-1:0]  window_len;
  logic           net_clear;
  logic           busy;
  logic           done;
  logic [CLW-1:0] class_out;
  logic [CW-1:0]  max_count;
  logic           tie;
  logic           class_valid;
  logic [CLW-1:0] cnt_sel;
  logic [CW-1:0]  cnt_dout;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_cnt [N];
  int exp_class;
  int exp_max;
  bit exp_tie;
  int prev_class = 0;
  int prev_max   = 0;
  bit prev_tie   = 1'b0;
  logic [N-1:0] pat_q [$];

  always #5 clk = ~clk;

  spike_count_decoder #(
    .NUM_OUTPUTS (N),
    .COUNT_WIDTH (CW),
    .WINDOW_WIDTH(WW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .spike_in   (spike_in),
    .start      (start),
    .abort      (abort),
    .window_len (window_len),
    .net_clear  (net_clear),
    .busy       (busy),
    .done       (done),
    .class_out  (class_out),
    .max_count  (max_count),
    .tie        (tie),
    .class_valid(class_valid),
    .cnt_sel    (cnt_sel),
    .cnt_dout   (cnt_dout)
  );

  // Winner = first index holding the largest count; tie = largest count held more than once
  function automatic void model_result();
    int m;
    int hits;
    m = 0;
    hits = 0;
    exp_class = -1;
    for (int i = 0; i < N; i++) if (exp_cnt[i] > m) m = exp_cnt[i];
    for (int i = 0; i < N; i++) begin
      if (exp_cnt[i] == m) begin
        hits++;
        if (exp_class < 0) exp_class = i;
      end
    end
    exp_max = m;
    exp_tie = (hits > 1);
  endfunction

  // k counts falling edges after the rising edge that samples start (edge 0)
  task automatic run_once(input int w, input int abort_k, input int restart_k,
                          input bit abort_done, input int rst_k);
    int lat;
    bit aborted;
    logic [N-1:0] s;
    logic [2:0] exp_ctl;
    lat = w + N + 1;
    aborted = (abort_k >= 0);
    for (int i = 0; i < N; i++) exp_cnt[i] = 0;
    @(negedge clk);
    start = 1'b1;
    window_len = WW'(w);
    for (int k = 0; k <= lat + 2; k++) begin
      @(negedge clk);
      if (k == rst_k) begin
        rst = 1'b0;
        cnt_sel = '0;
        #1;
        n_checks++;
        if ({busy, done, net_clear, tie, class_valid, class_out, max_count} !== '0) begin
          n_fail++;
          $display("FAIL reset_outputs: got %b, want all zero",
                   {busy, done, net_clear, tie, class_valid, class_out, max_count});
        end
        for (int i = 0; i < N; i++) begin
          cnt_sel = CLW'(i);
          #1;
          n_checks++;
          if (cnt_dout !== '0) begin
            n_fail++;
            $display("FAIL reset_cnt%0d: got %0d, want 0", i, cnt_dout);
          end
        end
        prev_class = 0;
        prev_max = 0;
        prev_tie = 1'b0;
        cnt_sel = '0;
        start = 1'b0;
        abort = 1'b0;
        pat_q.delete();
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      exp_ctl[2] = aborted ? (k <= abort_k) : (k <= lat);
      exp_ctl[1] = !aborted && (k == lat);
      exp_ctl[0] = (k == 0);
      n_checks++;
      if ({busy, done, net_clear} !== exp_ctl) begin
        n_fail++;
        $display("FAIL ctrl w=%0d k=%0d: busy/done/net_clear got %b, want %b",
                 w, k, {busy, done, net_clear}, exp_ctl);
      end
      s = N'($urandom_range(0, (1 << N) - 1));
      if (k >= 1 && k <= w) begin
        if (pat_q.size() > 0) s = pat_q[k-1];
        for (int i = 0; i < N; i++) begin
          if (s[i]) exp_cnt[i] = (exp_cnt[i] < SAT) ? exp_cnt[i] + 1 : SAT;
        end
      end
      spike_in = s;
      start = (k == restart_k);
      abort = (k == abort_k) || (abort_done && (k == lat || k == lat + 1));
      if (k >= 1) window_len = WW'($urandom);
    end
    start = 1'b0;
    abort = 1'b0;
    pat_q.delete();
    if (aborted) begin
      n_checks++;
      if ({class_out, max_count, tie, class_valid} !== {CLW'(prev_class), CW'(prev_max), prev_tie, 1'b0}) begin
        n_fail++;
        $display("FAIL abort_hold: class/max/tie/valid got %0d/%0d/%b/%b, want %0d/%0d/%b/0",
                 class_out, max_count, tie, class_valid, prev_class, prev_max, prev_tie);
      end
    end else begin
      model_result();
      n_checks++;
      if (class_out !== CLW'(exp_class)) begin
        n_fail++;
        $display("FAIL class_out w=%0d: got %0d, want %0d", w, class_out, exp_class);
      end
      n_checks++;
      if (max_count !== CW'(exp_max)) begin
        n_fail++;
        $display("FAIL max_count w=%0d: got %0d, want %0d", w, max_count, exp_max);
      end
      n_checks++;
      if (tie !== exp_tie) begin
        n_fail++;
        $display("FAIL tie w=%0d: got %b, want %b", w, tie, exp_tie);
      end
      n_checks++;
      if (class_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL class_valid w=%0d: got %b, want 1", w, class_valid);
      end
      for (int i = 0; i < N; i++) begin
        cnt_sel = CLW'(i);
        #1;
        n_checks++;
        if (cnt_dout !== CW'(exp_cnt[i])) begin
          n_fail++;
          $display("FAIL cnt_dout[%0d] w=%0d: got %0d, want %0d", i, w, cnt_dout, exp_cnt[i]);
        end
      end
      cnt_sel = '0;
      prev_class = exp_class;
      prev_max = exp_max;
      prev_tie = exp_tie;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      spike_in = N'($urandom_range(0, (1 << N) - 1));
      start = 1'b1;
    end
    n_checks++;
    if ({busy, done, net_clear, tie, class_valid, class_out, max_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %b, want all zero",
               {busy, done, net_clear, tie, class_valid, class_out, max_count});
    end
    start = 1'b0;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      spike_in = N'($urandom_range(0, (1 << N) - 1));
    end
    n_checks++;
    if ({busy, class_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy/valid got %b, want 00", {busy, class_valid});
    end
  endtask

  task automatic test_single_winner();
    for (int i = 0; i < 10; i++) pat_q.push_back(4'b0100);
    run_once(10, -1, -1, 1'b0, -1);
  endtask

  task automatic test_abort();
    run_once(10, 3, 2, 1'b0, -1);
  endtask

  task automatic test_tie();
    for (int i = 0; i < 3; i++) pat_q.push_back(4'b1010);
    for (int i = 0; i < 3; i++) pat_q.push_back(4'b0000);
    run_once(6, -1, -1, 1'b0, -1);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) pat_q.push_back(4'b0001);
    run_once(20, -1, -1, 1'b0, -1);
  endtask

  task automatic test_zero_window();
    run_once(0, -1, -1, 1'b0, -1);
  endtask

  task automatic test_abort_in_done();
    run_once(3, -1, -1, 1'b1, -1);
  endtask

  task automatic test_reset_mid_run();
    run_once(10, -1, -1, 1'b0, 12);
    for (int i = 0; i < 5; i++) pat_q.push_back(4'b1000);
    run_once(5, -1, -1, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      run_once($urandom_range(0, 24), -1, -1, 1'b0, -1);
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    spike_in = '0;
    window_len = '0;
    cnt_sel = '0;
    test_reset();
    test_single_winner();
    test_abort();
    test_tie();
    test_saturation();
    test_zero_window();
    test_abort_in_done();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
